// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and default geometry for the single-clock FIFO controller.
package sync_fifo_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 4;
   localparam int DEPTH = 1 << ADDR_WIDTH_DEFAULT;

   // Pointers carry one extra wrap bit above the memory address.
   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   typedef logic [ADDR_WIDTH_DEFAULT:0] ptr_t;

endpackage

// File: rtl/fifo_dual_port_ram.sv
// Storage array: one synchronous write port and one asynchronous read port.
module fifo_dual_port_ram
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_word,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_word
);

   logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (write_en) begin
         mem_q[write_addr] <= write_word;
      end
   end

   assign read_word = mem_q[read_addr];

endmodule

// File: rtl/sync_fifo_controller.sv
// Single-clock FIFO with guarded push/pop, fill level, programmable thresholds and sticky errors.
// Define SYNC_FIFO_CONTROLLER_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_controller
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDR_WIDTH         = 4,
   parameter int ALMOST_FULL_LEVEL  = 12,
   parameter int ALMOST_EMPTY_LEVEL = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic                  error_clear,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PW = ptr_width(ADDR_WIDTH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  full_w, empty_w;
   logic                  push_ok, pop_ok;
   logic [DATA_WIDTH-1:0] rd_word;

   // Full/empty come straight from the pointer registers, so acceptance never sees this cycle's inputs.
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

   assign push_ok = write_enable && !full_w;
   assign pop_ok  = read_enable && !empty_w;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q && !error_clear;
      underflow_d = underflow_q && !error_clear;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
      // A new error in the same cycle as a clear wins, so the flag is never lost.
      if (write_enable && full_w) begin
         overflow_d = 1'b1;
      end
      if (read_enable && empty_w) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clock      (clock),
      .write_en   (push_ok),
      .write_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .write_word (write_data),
      .read_addr  (rd_ptr_q[ADDR_WIDTH-1:0]),
      .read_word  (rd_word)
   );

`ifdef SYNC_FIFO_CONTROLLER_FWFT_EN
   assign read_data  = rd_word;
   assign read_valid = !empty_w;
`else
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= pop_ok;
         if (pop_ok) begin
            rd_data_q <= rd_word;
         end
      end
   end

   assign read_data  = rd_data_q;
   assign read_valid = rd_valid_q;
`endif

   assign full         = full_w;
   assign empty        = empty_w;
   assign fill_count   = count_q;
   assign almost_full  = (count_q >= PW'(ALMOST_FULL_LEVEL));
   assign almost_empty = (count_q <= PW'(ALMOST_EMPTY_LEVEL));
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_controller.sv
// Directed self-checking bench for sync_fifo_controller (8-bit data, 16 deep, levels 12/2).
module tb_sync_fifo_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] write_data;
   logic       write_enable;
   logic       read_enable;
   logic       error_clear;
   logic [7:0] read_data;
   logic       read_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [4:0] fill_count;
   logic       overflow;
   logic       underflow;

   int n_assert = 0;
   int n_fail   = 0;

   sync_fifo_controller #(
      .DATA_WIDTH         (8),
      .ADDR_WIDTH         (4),
      .ALMOST_FULL_LEVEL  (12),
      .ALMOST_EMPTY_LEVEL (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_enable  (read_enable),
      .error_clear  (error_clear),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fill_count   (fill_count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      write_data   = d;
      write_enable = 1'b1;
      step();
      write_enable = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk({tag, "_valid"}, 32'(read_valid), 32'd1);
      chk({tag, "_data"}, 32'(read_data), 32'(exp));
      read_enable = 1'b1;
      step();
      read_enable = 1'b0;
`else
      read_enable = 1'b1;
      step();
      read_enable = 1'b0;
      chk({tag, "_valid"}, 32'(read_valid), 32'd1);
      chk({tag, "_data"}, 32'(read_data), 32'(exp));
`endif
   endtask

   task automatic clear_errors();
      error_clear = 1'b1;
      step();
      error_clear = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_afull"}, 32'(almost_full), 32'd0);
      chk({tag, "_count"}, 32'(fill_count), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_udf"}, 32'(underflow), 32'd0);
      chk({tag, "_valid"}, 32'(read_valid), 32'd0);
`ifndef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk({tag, "_rdata"}, 32'(read_data), 32'd0);
`endif
   endtask

   initial begin
      reset        = 1'b1;
      write_data   = 8'h00;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      error_clear  = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      check_reset_state("reset");

      // Fill to the top, watching thresholds move with the count.
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         chk("fill_count", 32'(fill_count), 32'(i + 1));
         chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
         chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
         chk("fill_full", 32'(full), 32'((i + 1) == sync_fifo_pkg::DEPTH));
      end
      push(8'hAA);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(fill_count), 32'd16);
      chk("ovf_full", 32'(full), 32'd1);
      step();
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clear_errors();
      chk("ovf_cleared", 32'(overflow), 32'd0);

      for (int i = 0; i < 16; i++) begin
         pop_check("drain", 8'(i));
         chk("drain_count", 32'(fill_count), 32'(15 - i));
      end
      chk("drain_empty", 32'(empty), 32'd1);
      read_enable = 1'b1;
      step();
      read_enable = 1'b0;
      chk("udf_flag", 32'(underflow), 32'd1);
      chk("udf_count", 32'(fill_count), 32'd0);
`ifndef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("udf_no_valid", 32'(read_valid), 32'd0);
      chk("udf_hold_data", 32'(read_data), 32'h0F);
`endif
      clear_errors();
      chk("udf_cleared", 32'(underflow), 32'd0);

      // Pointers sit at 16 here; two rounds of ten cross the address wrap.
      for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
      for (int i = 0; i < 10; i++) pop_check("wrap_a", 8'(8'h10 + i));
      for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
      chk("wrap_count10", 32'(fill_count), 32'd10);
      for (int i = 0; i < 10; i++) pop_check("wrap_b", 8'(8'h20 + i));
      chk("wrap_count0", 32'(fill_count), 32'd0);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Simultaneous push+pop while full: pop wins, push rejected.
      for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
      chk("simfull_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("simfull_data", 32'(read_data), 32'h30);
`endif
      write_data   = 8'hBB;
      write_enable = 1'b1;
      read_enable  = 1'b1;
      step();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      chk("simfull_ovf", 32'(overflow), 32'd1);
      chk("simfull_count", 32'(fill_count), 32'd15);
      chk("simfull_notfull", 32'(full), 32'd0);
`ifndef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("simfull_data", 32'(read_data), 32'h30);
`endif
      // Clear coinciding with a fresh overflow keeps the flag set.
      push(8'h3F);
      chk("refill_full", 32'(full), 32'd1);
      write_data   = 8'hBC;
      write_enable = 1'b1;
      error_clear  = 1'b1;
      step();
      write_enable = 1'b0;
      error_clear  = 1'b0;
      chk("clear_vs_ovf", 32'(overflow), 32'd1);
      clear_errors();
      chk("clear_after", 32'(overflow), 32'd0);
      for (int i = 1; i < 16; i++) pop_check("simfull_drain", 8'(8'h30 + i));
      pop_check("simfull_last", 8'h3F);
      chk("simfull_empty", 32'(empty), 32'd1);

      // Simultaneous push+pop while empty: push wins, pop rejected.
      write_data   = 8'hCC;
      write_enable = 1'b1;
      read_enable  = 1'b1;
      step();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      chk("simempty_udf", 32'(underflow), 32'd1);
      chk("simempty_count", 32'(fill_count), 32'd1);
`ifndef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("simempty_novalid", 32'(read_valid), 32'd0);
`endif
      pop_check("simempty_pop", 8'hCC);
      clear_errors();

      // Simultaneous push+pop mid-level: count unchanged.
      for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
`ifdef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("sim5_data", 32'(read_data), 32'h40);
`endif
      write_data   = 8'h45;
      write_enable = 1'b1;
      read_enable  = 1'b1;
      step();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      chk("sim5_count", 32'(fill_count), 32'd5);
      chk("sim5_ovf", 32'(overflow), 32'd0);
      chk("sim5_udf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("sim5_valid", 32'(read_valid), 32'd1);
      chk("sim5_data", 32'(read_data), 32'h40);
`endif
      for (int i = 1; i < 6; i++) pop_check("sim5_drain", 8'(8'h40 + i));
      chk("sim5_empty", 32'(empty), 32'd1);

      // Mid-stream reset with seven words stored and a push pending.
      for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
      chk("mid_count7", 32'(fill_count), 32'd7);
      reset        = 1'b1;
      write_data   = 8'h77;
      write_enable = 1'b1;
      step();
      reset        = 1'b0;
      write_enable = 1'b0;
      check_reset_state("midreset");
      push(8'h55);
      chk("post_count", 32'(fill_count), 32'd1);
`ifdef SYNC_FIFO_CONTROLLER_FWFT_EN
      chk("post_fwft_valid", 32'(read_valid), 32'd1);
      chk("post_fwft_data", 32'(read_data), 32'h55);
`endif
      pop_check("post_pop", 8'h55);
      chk("post_empty", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
